omega_drift_generator: RTL and testbench



---
 rtl/omega_pkg.sv | 45 ++++
 rtl/omega_drift_generator_bounded_walk_step.sv | 48 ++++
 rtl/omega_drift_generator.sv | 209 ++++++++++++++++++++
 tb/tb_omega_drift_generator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/omega_pkg.sv
// omega_pkg: constants, state encoding and helpers shared by the omega drift
// generator and its walk-step sub-module.
//   - default output width and channel centers (OMEGA_DT units)
//   - 16-bit and 8-bit Galois LFSR taps, fallback/jitter seeds
//   - FSM state enum
//   - step decode (2 random bits -> -1/0/+1) and LFSR advance helpers
package omega_pkg;

  localparam int WIDTH_DEF        = 18;
  localparam int THETA_CENTER_DEF = 157;
  localparam int ALPHA_CENTER_DEF = 254;
  localparam int SR_CENTER_DEF    = 199;

  localparam logic [15:0] LFSR16_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR16_FALLBACK = 16'hACE1;
  localparam logic [7:0]  LFSR8_TAPS      = 8'hB8;
  localparam logic [7:0]  LFSR8_SEED      = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_THETA,
    ST_ALPHA,
    ST_SR,
    ST_COMMIT
  } state_e;

  // 00 -> -1, 01/10 -> 0, 11 -> +1
  function automatic logic signed [2:0] step_dir(input logic [1:0] bits);
    case (bits)
      2'b00:   step_dir = -3'sd1;
      2'b11:   step_dir = 3'sd1;
      default: step_dir = 3'sd0;
    endcase
  endfunction

  // Right-shifting Galois LFSR: feedback applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    lfsr16_next = s[0] ? ({1'b0, s[15:1]} ^ LFSR16_TAPS) : {1'b0, s[15:1]};
  endfunction

  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    lfsr8_next = s[0] ? ({1'b0, s[7:1]} ^ LFSR8_TAPS) : {1'b0, s[7:1]};
  endfunction

endpackage

// File: rtl/omega_drift_generator_bounded_walk_step.sv
// bounded_walk_step: combinational single step of a bounded random walk.
// Ports:
//   offset_i      signed 8-bit current offset
//   rnd_i         2 random bits selecting -STEP / 0 / +STEP
//   next_offset_o signed 8-bit offset after reflection and saturation
// Parameters STEP_SIZE (step magnitude) and DRIFT_MAX (offset bound).
module bounded_walk_step
  import omega_pkg::*;
#(
  parameter int STEP_SIZE = 1,
  parameter int DRIFT_MAX = 12
) (
  input  logic signed [7:0] offset_i,
  input  logic [1:0]        rnd_i,
  output logic signed [7:0] next_offset_o
);

  localparam logic signed [9:0] STEP = 10'(STEP_SIZE);
  localparam logic signed [9:0] LIM  = 10'(DRIFT_MAX);

  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    logic signed [9:0] r;
    r = v;
    if (v > LIM) r = LIM;
    else if (v < -LIM) r = -LIM;
    sat8 = r[7:0];
  endfunction

  logic signed [2:0] dir;
  logic signed [9:0] off_w;
  logic signed [9:0] step_w;
  logic signed [9:0] sum_w;

  always_comb begin
    dir    = step_dir(rnd_i);
    off_w  = {{2{offset_i[7]}}, offset_i};
    step_w = '0;
    if (dir > 3'sd0)      step_w = STEP;
    else if (dir < 3'sd0) step_w = -STEP;
    // Reflect off the walls before saturating, so a channel pinned at a
    // bound tends to move back toward center instead of sticking.
    if (step_w > 10'sd0 && off_w >= LIM)       step_w = -STEP;
    else if (step_w < 10'sd0 && off_w <= -LIM) step_w = STEP;
    sum_w         = off_w + step_w;
    next_offset_o = sat8(sum_w);
  end

endmodule

// File: rtl/omega_drift_generator.sv
// omega_drift_generator: three bounded random-walk oscillator frequencies
// (theta, alpha, SR1) in OMEGA_DT units, committed together as one triple.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   clk_en               sample-rate enable; gates the interval counter
//   enable               drift enable; 0 stops new update requests
//   seed_load, seed      load a new LFSR seed (0 maps to 16'hACE1)
//   omega_*_actual       signed outputs = center + offset (+ jitter)
//   drift_valid          one-cycle pulse with each committed triple
//   overrun              sticky: an update request was dropped
// Optional macro OMEGA_JITTER_EN adds +/-1 per-channel jitter driven by an
// 8-bit LFSR that advances on clk_en; outputs re-register every clk_en.
module omega_drift_generator
  import omega_pkg::*;
#(
  parameter int          WIDTH         = WIDTH_DEF,
  parameter int          THETA_CENTER  = THETA_CENTER_DEF,
  parameter int          ALPHA_CENTER  = ALPHA_CENTER_DEF,
  parameter int          SR_CENTER     = SR_CENTER_DEF,
  parameter int          DRIFT_MAX     = 12,
  parameter int          STEP_SIZE     = 1,
  parameter int          UPDATE_PERIOD = 1024,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    enable,
  input  logic                    seed_load,
  input  logic [15:0]             seed,
  output logic signed [WIDTH-1:0] omega_theta_actual,
  output logic signed [WIDTH-1:0] omega_alpha_actual,
  output logic signed [WIDTH-1:0] omega_sr_f0_actual,
  output logic                    drift_valid,
  output logic                    overrun
);

  localparam int CNT_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);

  localparam logic signed [WIDTH-1:0] THETA_C = WIDTH'(THETA_CENTER);
  localparam logic signed [WIDTH-1:0] ALPHA_C = WIDTH'(ALPHA_CENTER);
  localparam logic signed [WIDTH-1:0] SR_C    = WIDTH'(SR_CENTER);

  function automatic logic signed [WIDTH-1:0] sext8(input logic signed [7:0] v);
    sext8 = {{(WIDTH-8){v[7]}}, v};
  endfunction

  logic [CNT_W-1:0]  cnt_q;
  logic              pending_q;
  logic              overrun_q;
  logic [15:0]       lfsr_q;
  state_e            state_q;
  logic signed [7:0] off_theta_q, off_alpha_q, off_sr_q;
  logic signed [7:0] sh_theta_q, sh_alpha_q, sh_sr_q;
  logic signed [7:0] cur_off;
  logic signed [7:0] next_off;
  logic              tick, wrap, consume, chan_state, commit;

  assign tick       = clk_en && enable;
  assign wrap       = tick && (cnt_q == CNT_LAST);
  assign consume    = (state_q == ST_IDLE) && pending_q;
  assign chan_state = (state_q == ST_THETA) || (state_q == ST_ALPHA) || (state_q == ST_SR);
  assign commit     = (state_q == ST_COMMIT);
  assign overrun    = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // A request consumed by IDLE this cycle frees the slot, so a wrap on the
  // same edge is latched rather than counted as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (wrap) begin
      pending_q <= 1'b1;
      if (pending_q && !consume) overrun_q <= 1'b1;
    end else if (consume) begin
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (seed_load) begin
      lfsr_q <= (seed == 16'h0000) ? LFSR16_FALLBACK : seed;
    end else if (chan_state) begin
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

  // One walk-step instance serves all three channel states in turn.
  always_comb begin
    cur_off = '0;
    case (state_q)
      ST_THETA: cur_off = off_theta_q;
      ST_ALPHA: cur_off = off_alpha_q;
      ST_SR:    cur_off = off_sr_q;
      default:  cur_off = '0;
    endcase
  end

  bounded_walk_step #(
    .STEP_SIZE(STEP_SIZE),
    .DRIFT_MAX(DRIFT_MAX)
  ) u_walk (
    .offset_i     (cur_off),
    .rnd_i        (lfsr_q[1:0]),
    .next_offset_o(next_off)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      off_theta_q <= '0;
      off_alpha_q <= '0;
      off_sr_q    <= '0;
      sh_theta_q  <= '0;
      sh_alpha_q  <= '0;
      sh_sr_q     <= '0;
      drift_valid <= 1'b0;
    end else begin
      drift_valid <= 1'b0;
      case (state_q)
        ST_IDLE: if (pending_q) state_q <= ST_THETA;
        ST_THETA: begin
          sh_theta_q <= next_off;
          state_q    <= ST_ALPHA;
        end
        ST_ALPHA: begin
          sh_alpha_q <= next_off;
          state_q    <= ST_SR;
        end
        ST_SR: begin
          sh_sr_q <= next_off;
          state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          off_theta_q <= sh_theta_q;
          off_alpha_q <= sh_alpha_q;
          off_sr_q    <= sh_sr_q;
          drift_valid <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef OMEGA_JITTER_EN
  function automatic logic signed [WIDTH-1:0] sext3(input logic signed [2:0] v);
    sext3 = {{(WIDTH-3){v[2]}}, v};
  endfunction

  logic [7:0]        lfsr8_q, lfsr8_d;
  logic signed [2:0] jit_theta, jit_alpha, jit_sr;
  logic signed [7:0] base_theta, base_alpha, base_sr;

  // Jitter is taken from the LFSR value that will be held after this edge,
  // so the registered outputs always match lfsr8_q and a commit between
  // clk_en ticks does not introduce a fresh jitter value.
  always_comb begin
    lfsr8_d    = clk_en ? lfsr8_next(lfsr8_q) : lfsr8_q;
    jit_theta  = step_dir(lfsr8_d[1:0]);
    jit_alpha  = step_dir(lfsr8_d[3:2]);
    jit_sr     = step_dir(lfsr8_d[5:4]);
    base_theta = commit ? sh_theta_q : off_theta_q;
    base_alpha = commit ? sh_alpha_q : off_alpha_q;
    base_sr    = commit ? sh_sr_q    : off_sr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr8_q <= LFSR8_SEED;
    else     lfsr8_q <= lfsr8_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      omega_theta_actual <= THETA_C;
      omega_alpha_actual <= ALPHA_C;
      omega_sr_f0_actual <= SR_C;
    end else if (commit || clk_en) begin
      omega_theta_actual <= THETA_C + sext8(base_theta) + sext3(jit_theta);
      omega_alpha_actual <= ALPHA_C + sext8(base_alpha) + sext3(jit_alpha);
      omega_sr_f0_actual <= SR_C    + sext8(base_sr)    + sext3(jit_sr);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      omega_theta_actual <= THETA_C;
      omega_alpha_actual <= ALPHA_C;
      omega_sr_f0_actual <= SR_C;
    end else if (commit) begin
      omega_theta_actual <= THETA_C + sext8(sh_theta_q);
      omega_alpha_actual <= ALPHA_C + sext8(sh_alpha_q);
      omega_sr_f0_actual <= SR_C    + sext8(sh_sr_q);
    end
  end
`endif

endmodule

// File: tb/tb_omega_drift_generator.sv
module tb_omega_drift_generator;
  import omega_pkg::*;

  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_clk_en, a_enable, a_seed_load;
  logic [15:0] a_seed;
  logic signed [W-1:0] a_th, a_al, a_sr;
  logic a_dv, a_ov;

  logic b_rst, b_clk_en, b_enable, b_seed_load;
  logic [15:0] b_seed;
  logic signed [W-1:0] b_th, b_al, b_sr;
  logic b_dv, b_ov;

  omega_drift_generator #(
    .WIDTH(W), .DRIFT_MAX(2), .STEP_SIZE(1), .UPDATE_PERIOD(8), .SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(a_rst), .clk_en(a_clk_en), .enable(a_enable),
    .seed_load(a_seed_load), .seed(a_seed),
    .omega_theta_actual(a_th), .omega_alpha_actual(a_al), .omega_sr_f0_actual(a_sr),
    .drift_valid(a_dv), .overrun(a_ov)
  );

  omega_drift_generator #(
    .WIDTH(W), .DRIFT_MAX(0), .STEP_SIZE(1), .UPDATE_PERIOD(1), .SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rst(b_rst), .clk_en(b_clk_en), .enable(b_enable),
    .seed_load(b_seed_load), .seed(b_seed),
    .omega_theta_actual(b_th), .omega_alpha_actual(b_al), .omega_sr_f0_actual(b_sr),
    .drift_valid(b_dv), .overrun(b_ov)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] m_l;
  int m_off [3];

  function automatic logic [15:0] m_lfsr(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int m_walk(input int off, input logic [1:0] b, input int dm);
    int s;
    s = 0;
    if (b == 2'b00) s = -1;
    else if (b == 2'b11) s = 1;
    if (s > 0 && off >= dm) s = -1;
    else if (s < 0 && off <= -dm) s = 1;
    off = off + s;
    if (off > dm) off = dm;
    if (off < -dm) off = -dm;
    return off;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_clk_en = 1'b1; a_enable = 1'b1; a_seed_load = 1'b0; a_seed = 16'h0;
    tick(); tick();
    a_rst = 1'b0;
  endtask

  task automatic wait_dv_a(input int limit, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < limit) begin
      tick(); n++;
      if (a_dv) begin ok = 1'b1; break; end
    end
  endtask

  task automatic chk_a(input string nm, input int th, input int al, input int sr);
    checks++;
    if (a_th !== W'(th)) begin errors++; $display("FAIL %s theta: got %0d expected %0d", nm, a_th, th); end
    checks++;
    if (a_al !== W'(al)) begin errors++; $display("FAIL %s alpha: got %0d expected %0d", nm, a_al, al); end
    checks++;
    if (a_sr !== W'(sr)) begin errors++; $display("FAIL %s sr: got %0d expected %0d", nm, a_sr, sr); end
  endtask

  // Runs nupd updates from the current point and compares every committed
  // triple with the reference walk seeded by s.
  task automatic run_model(input logic [15:0] s, input int nupd, input string tag);
    int n; bit ok;
    m_l = s;
    for (int c = 0; c < 3; c++) m_off[c] = 0;
    for (int u = 0; u < nupd; u++) begin
      wait_dv_a(20, n, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL %s timeout at update %0d: no drift_valid in %0d cycles", tag, u, n);
        break;
      end
      for (int c = 0; c < 3; c++) begin
        m_off[c] = m_walk(m_off[c], m_l[1:0], 2);
        m_l = m_lfsr(m_l);
      end
      chk_a(tag, 157 + m_off[0], 254 + m_off[1], 199 + m_off[2]);
      checks++;
      if (a_th < 155 || a_th > 159 || a_al < 252 || a_al > 256 || a_sr < 197 || a_sr > 201) begin
        errors++;
        $display("FAIL %s range at update %0d: got %0d/%0d/%0d expected within +/-2 of 157/254/199",
                 tag, u, a_th, a_al, a_sr);
      end
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_clk_en = 1'b1; a_enable = 1'b1; a_seed_load = 1'b0; a_seed = 16'h0;
    b_rst = 1'b1; b_clk_en = 1'b1; b_enable = 1'b1; b_seed_load = 1'b0; b_seed = 16'h0;
    tick(); tick();
    chk_a("reset", 157, 254, 199);
    checks++;
    if (a_dv !== 1'b0) begin errors++; $display("FAIL reset drift_valid: got %b expected 0", a_dv); end
    checks++;
    if (a_ov !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b expected 0", a_ov); end
    a_rst = 1'b0;
  endtask

  task automatic test_first_updates();
    int n; bit ok;
    wait_dv_a(40, n, ok);
    checks++;
    if (!ok || n != 13) begin errors++; $display("FAIL latency1: got %0d cycles (seen=%0b) expected 13", n, ok); end
    chk_a("update1", 157, 253, 198);
    tick();
    checks++;
    if (a_dv !== 1'b0) begin errors++; $display("FAIL dv_pulse: got %b expected 0", a_dv); end
    wait_dv_a(20, n, ok);
    checks++;
    if (!ok || n != 7) begin errors++; $display("FAIL latency2: got %0d cycles (seen=%0b) expected 7", n, ok); end
    chk_a("update2", 156, 253, 199);
    repeat (5) tick();
    checks++;
    if (dut_a.state_q !== ST_ALPHA) begin errors++; $display("FAIL state_alpha: got %0d expected %0d", dut_a.state_q, ST_ALPHA); end
    a_rst = 1'b1;
    tick();
    chk_a("mid_reset", 157, 254, 199);
    checks++;
    if (dut_a.state_q !== ST_IDLE) begin errors++; $display("FAIL mid_reset state: got %0d expected %0d", dut_a.state_q, ST_IDLE); end
    checks++;
    if (a_dv !== 1'b0) begin errors++; $display("FAIL mid_reset dv: got %b expected 0", a_dv); end
    a_rst = 1'b0;
  endtask

  task automatic test_walk_model();
    reset_a();
    run_model(16'hACE1, 2000, "walk");
  endtask

  task automatic test_seed_load();
    for (int r = 0; r < 2; r++) begin
      reset_a();
      a_seed_load = 1'b1; a_seed = 16'h1234;
      tick();
      checks++;
      if (dut_a.lfsr_q !== 16'h1234) begin errors++; $display("FAIL seed_1234: got %h expected 1234", dut_a.lfsr_q); end
      a_seed = 16'h0000;
      tick();
      checks++;
      if (dut_a.lfsr_q !== 16'hACE1) begin errors++; $display("FAIL seed_zero: got %h expected ace1", dut_a.lfsr_q); end
      a_seed = 16'h1234;
      tick();
      a_seed_load = 1'b0;
      run_model(16'h1234, 20, (r == 0) ? "seed_run1" : "seed_run2");
    end
  endtask

  task automatic test_enable_off();
    int bad; int n; bit ok;
    reset_a();
    a_enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (a_dv !== 1'b0 || a_th !== W'(157) || a_al !== W'(254) || a_sr !== W'(199)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL enable_off: got %0d bad cycles expected 0", bad); end
    a_enable = 1'b1; a_clk_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_dv !== 1'b0 || dut_a.cnt_q !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clk_en_off: got %0d bad cycles expected 0", bad); end
    a_clk_en = 1'b1;
    wait_dv_a(40, n, ok);
    checks++;
    if (!ok || n != 13) begin errors++; $display("FAIL resume_latency: got %0d cycles (seen=%0b) expected 13", n, ok); end
  endtask

  task automatic test_overrun();
    int bad; logic exp_dv;
    b_rst = 1'b1; tick(); tick(); b_rst = 1'b0;
    tick();
    checks++;
    if (b_ov !== 1'b0) begin errors++; $display("FAIL overrun_c1: got %b expected 0", b_ov); end
    tick();
    checks++;
    if (b_ov !== 1'b0) begin errors++; $display("FAIL overrun_c2: got %b expected 0", b_ov); end
    tick();
    checks++;
    if (b_ov !== 1'b1) begin errors++; $display("FAIL overrun_c3: got %b expected 1", b_ov); end
    bad = 0;
    for (int k = 4; k <= 40; k++) begin
      tick();
      exp_dv = (k >= 6) && (((k - 6) % 5) == 0);
      checks++;
      if (b_dv !== exp_dv) begin errors++; $display("FAIL b_dv cycle %0d: got %b expected %b", k, b_dv, exp_dv); end
      if (b_th !== W'(157) || b_al !== W'(254) || b_sr !== W'(199)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b_centers: got %0d bad cycles expected 0", bad); end
    checks++;
    if (b_ov !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", b_ov); end
    b_rst = 1'b1;
    tick();
    checks++;
    if (b_ov !== 1'b0) begin errors++; $display("FAIL overrun_rst: got %b expected 0", b_ov); end
  endtask

  initial begin
    test_reset();
    test_first_updates();
    test_walk_model();
    test_seed_load();
    test_enable_off();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
